// File: rtl/stepdown_softstart_seq.sv
// stepdown_softstart_seq: soft-start sequencer for the stepdown output stage.
// Holds the output tri-stated for a precharge interval after enable, then
// ramps the reference code to full-scale. Over-current is monitored during
// ramp (after a blanking window) and run, and reported as a latched fault.
//
// Ports:
//   clk, rst_n          sequencer clock, async active-low reset
//   CELV, CELG, CELSUB  supply / ground / substrate pins, no logic attached
//   en                  stepdown enable (synchronous to clk)
//   ocp_flag            over-current comparator (asynchronous, synchronized here)
//   tstate              1 = output stage tri-stated, 0 = driving
//   ramp_code           soft-start reference code
//   pgood               ramp complete and no fault
//   fault               over-current fault latched
//   busy                high during PRECHARGE or RAMP
//
// Build option: define SS_RETRY_EN for hiccup mode (auto-restart from FAULT
// after RETRY_CYC cycles while enabled). Without it FAULT is sticky until
// en=0 or reset.

module stepdown_softstart_seq #(
  parameter int unsigned RAMP_W     = 8,
  parameter int unsigned STEP_DIV   = 16,
  parameter int unsigned PRECHG_CYC = 64,
  parameter int unsigned BLANK_CYC  = 32,
  parameter int unsigned RETRY_CYC  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              CELSUB,
  input  logic              en,
  input  logic              ocp_flag,
  output logic              tstate,
  output logic [RAMP_W-1:0] ramp_code,
  output logic              pgood,
  output logic              fault,
  output logic              busy
);

  localparam int unsigned PRECHG_W = (PRECHG_CYC > 1) ? $clog2(PRECHG_CYC) : 1;
  localparam int unsigned PRESC_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned BLANK_W  = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

  localparam logic [PRECHG_W-1:0] PRECHG_LAST = PRECHG_W'(PRECHG_CYC - 1);
  localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(STEP_DIV - 1);
  localparam logic [BLANK_W-1:0]  BLANK_DONE  = BLANK_W'(BLANK_CYC);
  localparam logic [RAMP_W-1:0]   RAMP_FULL   = '1;
  localparam logic [RAMP_W-1:0]   RAMP_PENULT = RAMP_FULL - RAMP_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_RAMP      = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PRECHG_W-1:0]  prechg_q, prechg_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [BLANK_W-1:0]   blank_q, blank_d;
  logic [RAMP_W-1:0]    ramp_q, ramp_d;
  logic                 ocp_meta_q, ocp_s_q;
  logic                 tstate_q, tstate_d;
  logic                 pgood_q, pgood_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic                 ocp_qual;

`ifdef SS_RETRY_EN
  localparam int unsigned RETRY_W = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(RETRY_CYC - 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`endif

  // Power pins are carried through the netlist only.
  logic unused_pins;
`ifdef SS_RETRY_EN
  assign unused_pins = ^{CELV, CELG, CELSUB};
`else
  assign unused_pins = ^{CELV, CELG, CELSUB, 1'(RETRY_CYC % 2)};
`endif

  // State register, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prechg_q   <= '0;
      presc_q    <= '0;
      blank_q    <= '0;
      ramp_q     <= '0;
      ocp_meta_q <= 1'b0;
      ocp_s_q    <= 1'b0;
      tstate_q   <= 1'b1;
      pgood_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SS_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      prechg_q   <= prechg_d;
      presc_q    <= presc_d;
      blank_q    <= blank_d;
      ramp_q     <= ramp_d;
      ocp_meta_q <= ocp_flag;
      ocp_s_q    <= ocp_meta_q;
      tstate_q   <= tstate_d;
      pgood_q    <= pgood_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
`ifdef SS_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  // OCP counts only in RUN, or in RAMP once the blanking counter has saturated.
  assign ocp_qual = ocp_s_q &&
                    ((state_q == ST_RUN) ||
                     ((state_q == ST_RAMP) && (blank_q == BLANK_DONE)));

  // Next-state and counter update; en=0 beats OCP, OCP beats progress.
  always_comb begin
    state_d  = state_q;
    prechg_d = prechg_q;
    presc_d  = presc_q;
    blank_d  = blank_q;
    ramp_d   = ramp_q;
`ifdef SS_RETRY_EN
    retry_d  = retry_q;
`endif
    if (!en) begin
      state_d  = ST_IDLE;
      prechg_d = '0;
      presc_d  = '0;
      blank_d  = '0;
      ramp_d   = '0;
`ifdef SS_RETRY_EN
      retry_d  = '0;
`endif
    end else if (ocp_qual) begin
      state_d  = ST_FAULT;
      prechg_d = '0;
      presc_d  = '0;
      blank_d  = '0;
      ramp_d   = '0;
`ifdef SS_RETRY_EN
      retry_d  = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d  = ST_PRECHARGE;
          prechg_d = '0;
          ramp_d   = '0;
        end
        ST_PRECHARGE: begin
          if (prechg_q == PRECHG_LAST) begin
            state_d  = ST_RAMP;
            prechg_d = '0;
            presc_d  = '0;
            blank_d  = '0;
            ramp_d   = '0;
          end else begin
            prechg_d = prechg_q + PRECHG_W'(1);
          end
        end
        ST_RAMP: begin
          if (blank_q != BLANK_DONE) begin
            blank_d = blank_q + BLANK_W'(1);
          end
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (ramp_q != RAMP_FULL) begin
              ramp_d = ramp_q + RAMP_W'(1);
            end
            // The step that lands on full-scale also completes the ramp.
            if (ramp_q == RAMP_PENULT) begin
              state_d = ST_RUN;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
        ST_RUN: begin
          ramp_d = RAMP_FULL;
        end
        ST_FAULT: begin
          ramp_d = '0;
`ifdef SS_RETRY_EN
          if (retry_q == RETRY_LAST) begin
            state_d  = ST_PRECHARGE;
            prechg_d = '0;
            retry_d  = '0;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
          ramp_d  = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs change on the transition edge.
  always_comb begin
    tstate_d = 1'b1;
    pgood_d  = 1'b0;
    fault_d  = 1'b0;
    busy_d   = 1'b0;
    unique case (state_d)
      ST_PRECHARGE: busy_d = 1'b1;
      ST_RAMP: begin
        tstate_d = 1'b0;
        busy_d   = 1'b1;
      end
      ST_RUN: begin
        tstate_d = 1'b0;
        pgood_d  = 1'b1;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  assign tstate    = tstate_q;
  assign ramp_code = ramp_q;
  assign pgood     = pgood_q;
  assign fault     = fault_q;
  assign busy      = busy_q;

endmodule
